// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-port RAM with registered read data.
// Define RAM_ARB_FIXED_PRIO_EN for fixed A-over-B priority; round-robin otherwise.
module ram_port_arbiter #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_a,
    input  logic             we_a,
    input  logic [AW-1:0]    addr_a,
    input  logic [WIDTH-1:0] wdata_a,
    input  logic             req_b,
    input  logic             we_b,
    input  logic [AW-1:0]    addr_b,
    input  logic [WIDTH-1:0] wdata_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             rvalid_a,
    output logic             rvalid_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             ram_cs_n,
    output logic             ram_we_n,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RDWAIT
    } state_t;

    state_t           state, state_nx;
    logic             cmd_we, cmd_we_nx;
    logic             owner_b, owner_b_nx;
    logic             pick_b;

    logic             gnt_a_nx, gnt_b_nx;
    logic             rvalid_a_nx, rvalid_b_nx;
    logic [WIDTH-1:0] rdata_a_nx, rdata_b_nx;
    logic             ram_cs_n_nx, ram_we_n_nx;
    logic [AW-1:0]    ram_addr_nx;
    logic [WIDTH-1:0] ram_wdata_nx;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign pick_b = req_b & ~req_a;
`else
    logic last_b, last_b_nx;

    // last_b resets high so that A is favoured first
    assign pick_b = req_b & (~req_a | ~last_b);
`endif

    always_comb begin
        state_nx     = state;
        cmd_we_nx    = cmd_we;
        owner_b_nx   = owner_b;
        gnt_a_nx     = 1'b0;
        gnt_b_nx     = 1'b0;
        rvalid_a_nx  = 1'b0;
        rvalid_b_nx  = 1'b0;
        rdata_a_nx   = rdata_a;
        rdata_b_nx   = rdata_b;
        ram_cs_n_nx  = 1'b1;
        ram_we_n_nx  = 1'b1;
        ram_addr_nx  = ram_addr;
        ram_wdata_nx = ram_wdata;
`ifndef RAM_ARB_FIXED_PRIO_EN
        last_b_nx    = last_b;
`endif
        case (state)
            S_IDLE: begin
                if (req_a || req_b) begin
                    owner_b_nx   = pick_b;
                    cmd_we_nx    = pick_b ? we_b : we_a;
                    ram_addr_nx  = pick_b ? addr_b : addr_a;
                    ram_wdata_nx = pick_b ? wdata_b : wdata_a;
                    ram_cs_n_nx  = 1'b0;
                    ram_we_n_nx  = ~cmd_we_nx;
                    gnt_a_nx     = ~pick_b;
                    gnt_b_nx     = pick_b;
`ifndef RAM_ARB_FIXED_PRIO_EN
                    last_b_nx    = pick_b;
`endif
                    state_nx     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nx = cmd_we ? S_IDLE : S_RDWAIT;
            end
            S_RDWAIT: begin
                if (owner_b) begin
                    rdata_b_nx  = ram_rdata;
                    rvalid_b_nx = 1'b1;
                end else begin
                    rdata_a_nx  = ram_rdata;
                    rvalid_a_nx = 1'b1;
                end
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cmd_we    <= 1'b0;
            owner_b   <= 1'b0;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            rvalid_a  <= 1'b0;
            rvalid_b  <= 1'b0;
            rdata_a   <= '0;
            rdata_b   <= '0;
            ram_cs_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state     <= state_nx;
            cmd_we    <= cmd_we_nx;
            owner_b   <= owner_b_nx;
            gnt_a     <= gnt_a_nx;
            gnt_b     <= gnt_b_nx;
            rvalid_a  <= rvalid_a_nx;
            rvalid_b  <= rvalid_b_nx;
            rdata_a   <= rdata_a_nx;
            rdata_b   <= rdata_b_nx;
            ram_cs_n  <= ram_cs_n_nx;
            ram_we_n  <= ram_we_n_nx;
            ram_addr  <= ram_addr_nx;
            ram_wdata <= ram_wdata_nx;
        end
    end

`ifndef RAM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_b <= 1'b1;
        else          last_b <= last_b_nx;
    end
`endif

endmodule
